jelly_data_ring_bus_ingress: RTL and testbench

JELLY_DATA_RING_BUS_INGRESS -- requirements
Module: jelly_data_ring_bus_ingress

---
 rtl/jelly_data_ring_bus_ingress_pkg.sv | 18 +
 rtl/jelly_data_ring_bus_ingress_fifo.sv | 73 +++++++
 rtl/jelly_data_ring_bus_ingress.sv | 84 ++++++++
 tb/tb_jelly_data_ring_bus_ingress.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jelly_data_ring_bus_ingress_pkg.sv
// Shared definitions for the ring-bus ingress: address window compare and FIFO count width.
package jelly_data_ring_bus_ingress_pkg;

  localparam int unsigned MISS_COUNT_WIDTH = 16;
  localparam int unsigned WINDOW_MAX_WIDTH = 64;

  function automatic int unsigned fifo_count_width(input int unsigned ptr_width);
    return ptr_width + 1;
  endfunction

  // Equivalent to (addr & mask) == (base & mask); callers zero-extend to WINDOW_MAX_WIDTH.
  function automatic logic window_match(input logic [WINDOW_MAX_WIDTH-1:0] addr,
                                        input logic [WINDOW_MAX_WIDTH-1:0] base,
                                        input logic [WINDOW_MAX_WIDTH-1:0] mask);
    return ((addr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/jelly_data_ring_bus_ingress_fifo.sv
// Synchronous FIFO with a registered head slot feeding m_* and a circular buffer behind it.
module jelly_data_ring_bus_ingress_fifo
  import jelly_data_ring_bus_ingress_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 2
) (
  input  logic                                  reset_n,
  input  logic                                  clk,
  input  logic                                  cke,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [DATA_WIDTH-1:0]                 m_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [fifo_count_width(PTR_WIDTH)-1:0] count
);

  localparam int unsigned DEPTH = 2 ** PTR_WIDTH;
  localparam int unsigned CW    = fifo_count_width(PTR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  mem_empty;
  logic                  load_head;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [CW-1:0]         count_next;

  // The buffer behind the head never holds more than DEPTH-1 entries, so equal pointers mean empty.
  always_comb begin
    push       = s_valid & s_ready & cke;
    pop        = m_valid & m_ready & cke;
    mem_empty  = (wr_ptr == rd_ptr);
    load_head  = cke & (~m_valid | m_ready);
    mem_rd     = load_head & ~mem_empty;
    mem_wr     = push & ~(load_head & mem_empty);
    count_next = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (cke) begin
      count   <= count_next;
      s_ready <= (count_next < CW'(DEPTH));
      if (mem_wr) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (mem_rd) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (load_head) begin
        m_valid <= mem_rd | push;
        if (mem_rd) begin
          m_data <= mem[rd_ptr];
        end else if (push) begin
          m_data <= s_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= s_data;
  end

endmodule

// File: rtl/jelly_data_ring_bus_ingress.sv
// Ring-bus ingress: decodes the request address to a destination id and queues {id, data}.
module jelly_data_ring_bus_ingress
  import jelly_data_ring_bus_ingress_pkg::*;
#(
  parameter int unsigned                   M_NUM      = 4,
  parameter int unsigned                   M_ID_WIDTH = 2,
  parameter int unsigned                   ADDR_WIDTH = 16,
  parameter int unsigned                   DATA_WIDTH = 32,
  parameter int unsigned                   PTR_WIDTH  = 2,
  parameter logic [M_NUM*ADDR_WIDTH-1:0]   M_BASE     = '0,
  parameter logic [M_NUM*ADDR_WIDTH-1:0]   M_MASK     = '0
) (
  input  logic                                   reset_n,
  input  logic                                   clk,
  input  logic                                   cke,
  input  logic [ADDR_WIDTH-1:0]                  s_addr,
  input  logic [DATA_WIDTH-1:0]                  s_data,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  output logic [M_ID_WIDTH-1:0]                  m_id_to,
  output logic [DATA_WIDTH-1:0]                  m_data,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic                                   err_miss,
  output logic [MISS_COUNT_WIDTH-1:0]            miss_count,
  output logic [fifo_count_width(PTR_WIDTH)-1:0] fifo_count
);

  localparam int unsigned FW = M_ID_WIDTH + DATA_WIDTH;

  logic                  hit;
  logic [M_ID_WIDTH-1:0] hit_id;
  logic                  accept;
  logic                  miss;
  logic [FW-1:0]         fifo_m_data;

  // Scan upward and latch the first match so the lowest index wins.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int unsigned i = 0; i < M_NUM; i++) begin
      if (!hit && window_match(WINDOW_MAX_WIDTH'(s_addr),
                               WINDOW_MAX_WIDTH'(M_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
                               WINDOW_MAX_WIDTH'(M_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
        hit    = 1'b1;
        hit_id = M_ID_WIDTH'(i);
      end
    end
  end

  assign accept = s_valid & s_ready & cke;
  assign miss   = accept & ~hit;

  jelly_data_ring_bus_ingress_fifo #(
    .DATA_WIDTH (FW),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_fifo (
    .reset_n (reset_n),
    .clk     (clk),
    .cke     (cke),
    .s_data  ({hit_id, s_data}),
    .s_valid (s_valid & hit),
    .s_ready (s_ready),
    .m_data  (fifo_m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .count   (fifo_count)
  );

  assign {m_id_to, m_data} = fifo_m_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_miss   <= 1'b0;
      miss_count <= '0;
    end else if (cke) begin
      err_miss <= miss;
      if (miss && (miss_count != '1)) miss_count <= miss_count + MISS_COUNT_WIDTH'(1);
    end else begin
      err_miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jelly_data_ring_bus_ingress.sv
// Testbench for jelly_data_ring_bus_ingress: directed scenarios plus random traffic against a queue model.
module tb_jelly_data_ring_bus_ingress;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cke = 1'b0;
  logic [15:0] s_addr = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  m_id_to;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        err_miss;
  logic [15:0] miss_count;
  logic [2:0]  fifo_count;

  logic [15:0] b_s_addr = '0;
  logic [31:0] b_s_data = '0;
  logic        b_s_valid = 1'b0;
  logic        b_s_ready;
  logic [1:0]  b_m_id_to;
  logic [31:0] b_m_data;
  logic        b_m_valid;
  logic        b_m_ready = 1'b0;
  logic        b_err_miss;
  logic [15:0] b_miss_count;
  logic [2:0]  b_fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jelly_data_ring_bus_ingress #(
    .M_NUM      (4),
    .M_ID_WIDTH (2),
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .PTR_WIDTH  (2),
    .M_BASE     ({16'h3000, 16'h2000, 16'h1000, 16'h0000}),
    .M_MASK     ({16'hF000, 16'hF000, 16'hF000, 16'hF000})
  ) dut (
    .reset_n (reset_n), .clk (clk), .cke (cke),
    .s_addr (s_addr), .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
    .m_id_to (m_id_to), .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready),
    .err_miss (err_miss), .miss_count (miss_count), .fifo_count (fifo_count)
  );

  // Window 1 matches every address, so only window 0 can beat it.
  jelly_data_ring_bus_ingress #(
    .M_NUM      (4),
    .M_ID_WIDTH (2),
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .PTR_WIDTH  (2),
    .M_BASE     ({16'h3000, 16'h2000, 16'h1000, 16'h0000}),
    .M_MASK     ({16'hF000, 16'hF000, 16'h0000, 16'hF000})
  ) dut_b (
    .reset_n (reset_n), .clk (clk), .cke (cke),
    .s_addr (b_s_addr), .s_data (b_s_data), .s_valid (b_s_valid), .s_ready (b_s_ready),
    .m_id_to (b_m_id_to), .m_data (b_m_data), .m_valid (b_m_valid), .m_ready (b_m_ready),
    .err_miss (b_err_miss), .miss_count (b_miss_count), .fifo_count (b_fifo_count)
  );

  typedef struct {
    int unsigned id;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_miss;
  bit          m_err;
  bit          m_sr;

  function automatic int ref_dest(input logic [15:0] a);
    logic [3:0] top;
    top = a[15:12];
    return (top < 4) ? int'(top) : -1;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_miss = 0;
    m_err  = 1'b0;
    m_sr   = 1'b0;
  endfunction

  function automatic void model_step();
    bit   acc;
    int   d;
    ent_t e;
    if (!cke) begin
      m_err = 1'b0;
      return;
    end
    acc = s_valid && m_sr;
    if ((mq.size() > 0) && m_ready) void'(mq.pop_front());
    m_err = 1'b0;
    if (acc) begin
      d = ref_dest(s_addr);
      if (d >= 0) begin
        e.id   = d;
        e.data = s_data;
        mq.push_back(e);
      end else begin
        m_err = 1'b1;
        if (m_miss < 65535) m_miss++;
      end
    end
    m_sr = (mq.size() < 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cke = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_m_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b want 0", s_ready); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    checks++; if (err_miss !== 1'b0) begin errors++; $display("FAIL reset_err_miss got %0b want 0", err_miss); end
    checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL reset_miss_count got %0h want 0", miss_count); end
    checks++; if ({m_id_to, m_data} !== 34'd0) begin errors++; $display("FAIL reset_head got %0h/%0h want 0/0", m_id_to, m_data); end
    reset_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready got %0b want 1", s_ready); end
  endtask

  task automatic test_decode();
    s_addr = 16'h2ABC; s_data = 32'h11; s_valid = 1'b1; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL decode_m_valid got %0b want 1", m_valid); end
    checks++; if (m_id_to !== 2'd2) begin errors++; $display("FAIL decode_id got %0d want 2", m_id_to); end
    checks++; if (m_data !== 32'h11) begin errors++; $display("FAIL decode_data got %0h want 11", m_data); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL decode_count got %0d want 1", fifo_count); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL decode_drain got %0b want 0", m_valid); end
  endtask

  task automatic test_overlap();
    b_s_addr = 16'h0123; b_s_data = 32'hA5; b_s_valid = 1'b1; b_m_ready = 1'b1;
    tick();
    checks++; if (b_m_valid !== 1'b1 || b_m_id_to !== 2'd0) begin errors++; $display("FAIL overlap_low got v=%0b id=%0d want v=1 id=0", b_m_valid, b_m_id_to); end
    b_s_addr = 16'h5000;
    tick();
    b_s_valid = 1'b0;
    checks++; if (b_m_valid !== 1'b1 || b_m_id_to !== 2'd1) begin errors++; $display("FAIL overlap_catchall got v=%0b id=%0d want v=1 id=1", b_m_valid, b_m_id_to); end
    tick();
  endtask

  task automatic test_miss();
    s_addr = 16'h8000; s_data = 32'hDEAD; s_valid = 1'b1; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    checks++; if (err_miss !== 1'b1) begin errors++; $display("FAIL miss_pulse got %0b want 1", err_miss); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL miss_no_valid got %0b want 0", m_valid); end
    checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL miss_count got %0d want 1", miss_count); end
    tick();
    checks++; if (err_miss !== 1'b0) begin errors++; $display("FAIL miss_pulse_end got %0b want 0", err_miss); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    bit acc;
    m_ready = 1'b0; s_valid = 1'b1; s_addr = 16'h1000;
    for (int k = 1; k <= 5; k++) begin
      s_data = 32'(k);
      tick();
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d want 4", fifo_count); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got %0b want 0", s_ready); end
    checks++; if (m_data !== 32'd1) begin errors++; $display("FAIL bp_head got %0d want 1", m_data); end
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (m_valid) got.push_back(m_data);
      acc = s_valid && s_ready;
      tick();
      if (acc) s_valid = 1'b0;
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_out_count got %0d want 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++; if (got[k] !== 32'(k + 1)) begin errors++; $display("FAIL bp_order[%0d] got %0d want %0d", k, got[k], k + 1); end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_stream();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s_data = 32'(100 + c);
      s_addr = 16'h3000 | 16'(c);
      tick();
      checks++; if (fifo_count !== 3'd1 || m_data !== 32'(100 + c) || m_id_to !== 2'd3) begin
        errors++; $display("FAIL stream[%0d] got cnt=%0d data=%0d id=%0d want cnt=1 data=%0d id=3", c, fifo_count, m_data, m_id_to, 100 + c);
      end
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] top;
    for (int c = 0; c < 400; c++) begin
      cke     = ($urandom_range(0, 7) != 0);
      s_valid = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 2) != 0;
      top     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      s_addr  = {top, 12'($urandom)};
      s_data  = $urandom;
      tick();
      checks++; if (m_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_m_valid[%0d] got %0b want %0b", c, m_valid, mq.size() > 0); end
      checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", c, fifo_count, mq.size()); end
      checks++; if (s_ready !== m_sr) begin errors++; $display("FAIL rand_s_ready[%0d] got %0b want %0b", c, s_ready, m_sr); end
      checks++; if (err_miss !== m_err) begin errors++; $display("FAIL rand_err_miss[%0d] got %0b want %0b", c, err_miss, m_err); end
      checks++; if (miss_count !== 16'(m_miss)) begin errors++; $display("FAIL rand_miss_count[%0d] got %0d want %0d", c, miss_count, m_miss); end
      if (mq.size() > 0) begin
        checks++; if (m_id_to !== 2'(mq[0].id) || m_data !== mq[0].data) begin
          errors++; $display("FAIL rand_head[%0d] got %0d/%0h want %0d/%0h", c, m_id_to, m_data, mq[0].id, mq[0].data);
        end
      end
    end
    cke = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1; s_valid = 1'b0;
    repeat (6) tick();
    m_ready = 1'b0; s_valid = 1'b1; s_addr = 16'h0040;
    for (int g = 0; g < 20 && mq.size() < 3; g++) begin
      s_data = 32'(200 + g);
      tick();
    end
    s_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_prefill got %0d want 3", fifo_count); end
    reset_n = 1'b0;
    model_clear();
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid got %0b want 0", m_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", fifo_count); end
    @(negedge clk);
    reset_n = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale[%0d] got %0b want 0", c, m_valid); end
    end
  endtask

  task automatic test_saturate();
    int guard;
    s_addr = 16'h8000; s_valid = 1'b1; m_ready = 1'b1; cke = 1'b1;
    guard = 0;
    while (m_miss < 65535 && guard < 70000) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    checks++; if (guard >= 70000) begin errors++; $display("FAIL sat_timeout got %0d cycles want <70000", guard); end
    checks++; if (miss_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %0h want ffff", miss_count); end
    checks++; if (err_miss !== 1'b1) begin errors++; $display("FAIL sat_err_miss got %0b want 1", err_miss); end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_overlap();
    test_miss();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
